// File: rtl/shift_pkg.sv
// Shared definitions for the shift request front end: op encodings, shifter
// geometry and the bit-reverse helper used to build left shifts from right ones.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int SH_LAT = 5;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_ROR = 2'b01,
        OP_SLL = 2'b10,
        OP_ROL = 2'b11
    } shift_op_e;

    function automatic logic [DATA_W-1:0] bitRev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_resp_fifo.sv
// Synchronous response FIFO; count_o exposes occupancy so the issue side can
// reserve space before an operation enters the shifter.
module shift_resp_fifo
    import shift_pkg::*;
#(
    parameter int WIDTH = DATA_W + 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdData_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             full;
    logic             empty;
    logic             doPush;
    logic             doPop;

    assign count_o  = wrPtr_q - rdPtr_q;
    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush   = push_i && !full;
    assign doPop    = pop_i && !empty;
    assign rdData_o = mem_q[rdPtr_q[AW-1:0]];

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_issue_ctrl.sv
// Request/response front end for the fixed-latency right-shift/rotate datapath.
// Ops are tagged, tracked through the shifter latency and buffered in a credit-gated FIFO.
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_data,
    input  logic [4:0]        req_amt,
    input  logic [1:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       sh_a,
    output logic [4:0]        sh_sel,
    output logic              sh_rotate,
    input  logic [31:0]       sh_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = DATA_W + TAG_W;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic             valid;
        logic             rev;
        logic [TAG_W-1:0] tag;
    } track_t;

    shift_op_e        reqOp;
    logic             fire;
    logic             isLeft;
    logic             isRot;
    track_t           pipe_q [SH_LAT];
    track_t           pipe_d [SH_LAT];
    track_t           aligned;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   credUsed;
    logic [DATA_W-1:0] capData;
    logic [ENT_W-1:0] fifoRd;
    logic             pop;

    assign reqOp  = shift_op_e'(req_op);
    assign isLeft = (reqOp == OP_SLL) || (reqOp == OP_ROL);
    assign isRot  = (reqOp == OP_ROR) || (reqOp == OP_ROL);
    assign fire   = req_valid && req_ready;

    // Left ops ride the right-only shifter by reversing bits on the way in and out.
    always_comb begin
        sh_a      = '0;
        sh_sel    = '0;
        sh_rotate = 1'b0;
        if (fire) begin
            sh_a      = isLeft ? bitRev(req_data) : req_data;
            sh_sel    = req_amt;
            sh_rotate = isRot;
        end
    end

    always_comb begin
        pipe_d[0] = '{valid: fire, rev: isLeft, tag: req_tag};
        for (int i = 1; i < SH_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SH_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SH_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i].valid);
        end
    end

    // Every op in the shifter already owns a FIFO slot, so the FIFO can never overflow.
    assign credUsed  = {1'b0, inflight} + {1'b0, occ};
    assign req_ready = !rst && (credUsed < CREDIT_MAX);
    assign busy      = (inflight != '0) || (occ != '0);

    assign aligned = pipe_q[SH_LAT-1];
    assign capData = aligned.rev ? bitRev(sh_b) : sh_b;

    assign resp_valid = (occ != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifoRd[ENT_W-1:TAG_W];
    assign resp_tag   = fifoRd[TAG_W-1:0];

    shift_resp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (aligned.valid),
        .pushData_i ({capData, aligned.tag}),
        .pop_i      (pop),
        .rdData_o   (fifoRd),
        .count_o    (occ)
    );

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Scoreboard bench for shift_issue_ctrl with a behavioural 5-stage shifter attached.
// Expected results come from plain shift/rotate arithmetic on the request fields.
module tb_shift_issue_ctrl;

    localparam int FIFO_DEPTH = 8;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic [4:0]  req_amt = '0;
    logic [1:0]  req_op = '0;
    logic [3:0]  req_tag = '0;
    logic [31:0] sh_a;
    logic [4:0]  sh_sel;
    logic        sh_rotate;
    logic [31:0] sh_b;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          stallCnt = 0;
    int          respCount = 0;
    int          acceptCount = 0;
    int          respMode = 0;
    logic        latChk = 1'b0;
    logic [31:0] lastRespData = '0;
    exp_t        sbQ[$];

    logic [31:0] shPipe [5];

    shift_issue_ctrl #(
        .TAG_W      (4),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_op     (req_op),
        .req_tag    (req_tag),
        .sh_a       (sh_a),
        .sh_sel     (sh_sel),
        .sh_rotate  (sh_rotate),
        .sh_b       (sh_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // External shifter: right shift or rotate, result after five register stages, never reset.
    always @(posedge clk) begin
        shPipe[0] <= sh_rotate ? 32'({sh_a, sh_a} >> sh_sel) : (sh_a >> sh_sel);
        for (int i = 1; i < 5; i++) shPipe[i] <= shPipe[i-1];
    end
    assign sh_b = shPipe[4];

    // Consumer: 0 = stalled, 1 = always ready, 2 = random.
    always begin
        @(posedge clk);
        #2;
        case (respMode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        logic [63:0] dbl;
        dbl = {d, d};
        case (op)
            2'd0:    return d >> a;
            2'd1:    return 32'(dbl >> a);
            2'd2:    return d << a;
            default: return 32'((dbl << a) >> 32);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pops and compares on every response, pushes expectations on every accept.
    logic        holdPending = 1'b0;
    logic [31:0] holdData = '0;
    logic [3:0]  holdTag = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (holdPending && resp_valid) begin
                check("resp_data_stable", resp_data, holdData);
                check("resp_tag_stable", 32'(resp_tag), 32'(holdTag));
            end
            holdPending = resp_valid && !resp_ready;
            holdData    = resp_data;
            holdTag     = resp_tag;
            if (resp_valid && resp_ready) begin
                respCount++;
                check("sb_has_entry", 32'(sbQ.size() != 0), 32'd1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_tag", 32'(resp_tag), 32'(e.tag));
                    if (latChk) check("resp_latency", 32'(cycle - e.cyc), 32'd6);
                end
                lastRespData = resp_data;
            end
            if (dut.u_fifo.push_i) begin
                check("fifo_no_overflow", 32'(dut.u_fifo.count_o != FIFO_DEPTH), 32'd1);
            end
            if (req_valid && req_ready) begin
                acceptCount++;
                sbQ.push_back('{refShift(req_data, req_amt, req_op), req_tag, cycle});
            end
        end else begin
            sbQ.delete();
            holdPending = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op, input logic [3:0] tag);
        int waitCnt;
        waitCnt   = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_op    = op;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && waitCnt < 300) begin
            waitCnt++;
            @(negedge clk);
        end
        stallCnt += waitCnt;
        check("req_accept_in_time", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sbQ.size() != 0) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("drain_in_time", 32'(n < 500), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] dirExp [4];
        int          accepted;
        dirExp[0] = 32'h0800_0000;
        dirExp[1] = 32'h1800_0000;
        dirExp[2] = 32'h0000_0010;
        dirExp[3] = 32'h0000_0018;

        #3;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed ops on 0x80000001 amt 4");
        respMode = 1;
        latChk   = 1'b1;
        for (int op = 0; op < 4; op++) begin
            applyStimulus(32'h8000_0001, 5'd4, 2'(op), 4'(op));
            waitIdle();
            check("directed_result", lastRespData, dirExp[op]);
        end

        $display("[TB] back-to-back ROR stream");
        stallCnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(32'(i), 5'(i % 32), 2'd1, 4'(i));
        end
        check("b2b_no_stall", 32'(stallCnt), 32'd0);
        waitIdle();

        $display("[TB] stalled consumer fills credits");
        respMode = 0;
        latChk   = 1'b0;
        accepted = 0;
        for (int c = 0; c < 14; c++) begin
            req_valid = 1'b1;
            req_data  = 32'hA500_0000 + 32'(accepted);
            req_amt   = 5'(accepted * 3);
            req_op    = 2'($urandom_range(0, 3));
            req_tag   = 4'(accepted);
            @(negedge clk);
            if (req_ready) accepted++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("stall_accept_count", 32'(accepted), 32'd8);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        respMode = 1;
        @(negedge clk);
        check("ready_before_pop", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_pop", 32'(req_ready), 32'd1);
        waitIdle();

        $display("[TB] amount zero on all ops");
        latChk = 1'b1;
        for (int op = 0; op < 4; op++) begin
            applyStimulus(32'hDEAD_BEEF, 5'd0, 2'(op), 4'(4 + op));
            waitIdle();
            check("amt0_identity", lastRespData, 32'hDEAD_BEEF);
        end

        $display("[TB] reset with ops in flight");
        applyStimulus(32'h11, 5'd1, 2'd0, 4'hA);
        applyStimulus(32'h22, 5'd2, 2'd1, 4'hB);
        applyStimulus(32'h33, 5'd3, 2'd2, 4'hC);
        repeat (2) @(posedge clk);
        #2;
        check("busy_before_reset", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_resp_after_reset", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h1, 5'd31, 2'd2, 4'h5);
        waitIdle();
        check("post_reset_sll", lastRespData, 32'h8000_0000);

        $display("[TB] randomized ops with random consumer");
        respMode    = 2;
        latChk      = 1'b0;
        respCount   = 0;
        acceptCount = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        waitIdle();
        check("random_resp_count", 32'(respCount), 32'(acceptCount));
        check("random_accept_count", 32'(acceptCount), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
